// File: rtl/port0_serial_tx.sv
// port0_serial_tx: FIFO-buffered 16-bit UART-style transmitter fed by Port0 writes.
// Define PORT0_TX_PARITY_EN to add an even-parity bit between data bit 15 and stop.
module port0_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        overflow,
    output logic        done
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef PORT0_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state, state_next;
    logic [15:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_next;
    logic [BW-1:0] baud, baud_next;
    logic [3:0] bit_cnt;
    logic [15:0] shift;
    logic baud_last, push, pop;
`ifdef PORT0_TX_PARITY_EN
    logic par;
`endif
    assign full = count == (AW+1)'(DEPTH);
    assign push = load && !full;
    assign baud_last = baud == BW'(CLKS_PER_BIT - 1);
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    assign baud_next = (state == IDLE || state_next != state || baud_last) ? '0 : baud + 1'b1;
    always_comb begin
        state_next = state;
        pop = 1'b0;
        tx = 1'b1;
        case (state)
            IDLE: begin
                pop = count != '0;
                state_next = pop ? START : IDLE;
            end
            START: begin
                tx = 1'b0;
                if (baud_last) state_next = DATA;
            end
            DATA: begin
                tx = shift[0];
                if (baud_last && bit_cnt == 4'd15)
`ifdef PORT0_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
            end
`ifdef PORT0_TX_PARITY_EN
            PARITY: begin
                tx = par;
                if (baud_last) state_next = STOP;
            end
`endif
            STOP: begin
                if (baud_last) begin
                    pop = count != '0;
                    state_next = pop ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= data_in;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            baud <= '0;
            bit_cnt <= '0;
            shift <= '0;
            busy <= 1'b0;
            overflow <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            baud <= baud_next;
            busy <= state_next != IDLE || count_next != '0;
            overflow <= overflow | (load & full);
            done <= state == STOP && baud_last;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                shift <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end else if (state == DATA && baud_last) begin
                shift <= shift >> 1;
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end
`ifdef PORT0_TX_PARITY_EN
    // parity is latched at pop because the shift register is consumed by the data bits
    always_ff @(posedge clk) if (pop) par <= ^mem[rd_ptr];
`endif
endmodule
